lcd_bus_ctrl: RTL and testbench
===============================

LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 Parameter T_AS, default 1: address/RS/RW setup cycles before lcd_e rises; legal range 0-15.
REQ-002 Parameter T_PW, default 4: lcd_e high cycles; legal range 1-15.
REQ-003 Parameter T_AH, default 1: hold cycles after lcd_e falls; legal range 0-15.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 a  input  16  CPU address bus.
REQ-007 n_oe  input  1  CPU read strobe, active low.
REQ-008 n_we  input  1  CPU write strobe, active low.
REQ-009 d_in  input  8  CPU write data.
REQ-010 d_out  output  8  read data to CPU.
REQ-011 d_out_oe  output  1  high while d_out drives the CPU bus.
REQ-012 n_rdy  output  1  CPU wait request; 1 = stall, 0 = ready.
REQ-013 lcd_e  output  1  HD44780 enable strobe.
REQ-014 lcd_rs  output  1  register select (0 = command/status, 1 = data).
REQ-015 lcd_rw  output  1  1 = LCD read, 0 = LCD write.
REQ-016 lcd_d_out  output  8  data driven to LCD.
REQ-017 lcd_d_oe  output  1  high while lcd_d_out drives the LCD bus.
REQ-018 lcd_d_in  input  8  data returned by the LCD.

Function
REQ-019 LCD access = a[15:8]==8'hFF, a[2]==0, a[1]==1, and (n_oe==0 or n_we==0); a[0] selects RS (0xFF02 command/status, 0xFF03 data).
REQ-020 n_oe and n_we both low: treated as write.
REQ-021 States: IDLE, SETUP, PULSE, HOLD, DONE; one shared 4-bit down-counter times SETUP/PULSE/HOLD.
REQ-022 IDLE: on access, latch rs=a[0], rw=~write, wdata=d_in; go to SETUP with counter=T_AS, or straight to PULSE if T_AS==0.
REQ-023 SETUP: lcd_e=0, lcd_rs/lcd_rw driven from latches; leave when counter reaches 0.
REQ-024 PULSE: lcd_e=1 for exactly T_PW cycles; on the last PULSE cycle, if rw==1, latch lcd_d_in into d_out register.
REQ-025 HOLD: lcd_e=0, rs/rw/lcd_d_out unchanged for T_AH cycles (skipped when 0), then DONE.
REQ-026 DONE: wait until access deasserts (both strobes high, or address leaves the LCD window), then IDLE; no new sequence starts from DONE.
REQ-027 n_rdy combinational: 1 when access is true and state != DONE, else 0; n_rdy = 0 whenever no LCD access.
REQ-028 Write latency: n_rdy falls T_AS+T_PW+T_AH+1 cycles after first sampled access cycle (1 IDLE cycle + timed states).
REQ-029 lcd_d_oe = 1 from SETUP through HOLD when rw==0; 0 otherwise; lcd_d_out = latched wdata.
REQ-030 d_out_oe = 1 only in DONE with rw==1 and n_oe==0.
REQ-031 Access withdrawn mid-sequence (CPU abort): sequence still completes through HOLD, passes DONE, returns to IDLE; lcd_e never truncated.
REQ-032 Changes on a, d_in, n_oe, n_we after IDLE have no effect on LCD outputs until IDLE again.

Reset
REQ-033 rst high on a clock edge: state=IDLE, counter=0, lcd_e=0, lcd_rs=0, lcd_rw=1, lcd_d_oe=0, d_out=8'h00, d_out_oe=0; applies mid-sequence, lcd_e low from the next edge.
REQ-034 During rst, n_rdy = 0.

Structure
REQ-035 Shared package ccpu_io_pkg: LCD address constants (8'hFF page, offsets 2/3), state enum, timing default constants.
REQ-036 One sub-module, io_cycle_timer: loadable 4-bit down-counter with zero flag; FSM in lcd_bus_ctrl.

Verification
REQ-037 Write 8'h38 to 0xFF02, defaults: lcd_rs=0, lcd_rw=0, lcd_d_out=8'h38, lcd_e high exactly 4 cycles after 1 setup cycle, n_rdy high 7 cycles then 0.
REQ-038 Read 0xFF02 with lcd_d_in=8'h80 during PULSE: d_out=8'h80, d_out_oe=1 in DONE, lcd_d_oe=0 throughout.
REQ-039 n_oe and n_we both low at 0xFF03, d_in=8'h41: write performed, lcd_rs=1, lcd_rw=0.
REQ-040 rst asserted in 2nd PULSE cycle: lcd_e=0 next edge, state IDLE, n_rdy=0; next write runs full timing.
REQ-041 Strobe withdrawn after 2 cycles: lcd_e still high full T_PW, n_rdy=0 immediately, FSM back in IDLE after HOLD+DONE.
REQ-042 Access to 0xFF04 (keyboard) and 0x7F02: no state change, lcd_e stays 0, n_rdy=0.

Source files
------------

// File: rtl/ccpu_io_pkg.sv
// Shared I/O definitions for the CPU-side peripheral bridges: LCD address map,
// bus-cycle state encoding and default HD44780 timing.
package ccpu_io_pkg;

  localparam logic [7:0] LCD_PAGE     = 8'hFF;
  localparam logic [2:0] LCD_OFF_CMD  = 3'd2;
  localparam logic [2:0] LCD_OFF_DATA = 3'd3;

  localparam int T_AS_DEF = 1;
  localparam int T_PW_DEF = 4;
  localparam int T_AH_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } lcd_state_e;

  // Command (offset 2) and data (offset 3) share a[2:1]; a[0] later picks RS.
  function automatic logic is_lcd_addr(input logic [15:0] addr);
    return (addr[15:8] == LCD_PAGE) && (addr[2:1] == LCD_OFF_CMD[2:1]);
  endfunction

endpackage

// File: rtl/io_cycle_timer.sv
// Loadable 4-bit down-counter that times the phases of one I/O bus cycle.
module io_cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Bridges CPU accesses at 0xFF02/0xFF03 onto an HD44780 bus, stretching the CPU
// cycle with n_rdy until the full setup/enable/hold sequence has completed.
module lcd_bus_ctrl
  import ccpu_io_pkg::*;
#(
  parameter int T_AS = T_AS_DEF,
  parameter int T_PW = T_PW_DEF,
  parameter int T_AH = T_AH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        n_oe,
  input  logic        n_we,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_out_oe,
  output logic        n_rdy,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_d_out,
  output logic        lcd_d_oe,
  input  logic [7:0]  lcd_d_in
);

  // The timer holds "remaining cycles - 1", so a phase ends on the zero flag.
  localparam logic [3:0] AS_LD = 4'(T_AS - 1);
  localparam logic [3:0] PW_LD = 4'(T_PW - 1);
  localparam logic [3:0] AH_LD = 4'(T_AH - 1);

  lcd_state_e state_q, state_d;
  logic       rs_q, rs_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       lcd_e_q, lcd_d_oe_q;
  logic       access, wr_req;
  logic       tmr_load, tmr_zero;
  logic [3:0] tmr_val;

  assign access = is_lcd_addr(a) && (!n_oe || !n_we);
  assign wr_req = !n_we;

  io_cycle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state logic; request fields are captured only when leaving IDLE.
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          rs_d     = a[0];
          rw_d     = ~wr_req;
          wdata_d  = d_in;
          tmr_load = 1'b1;
          if (T_AS != 0) begin
            state_d = S_SETUP;
            tmr_val = AS_LD;
          end else begin
            state_d = S_PULSE;
            tmr_val = PW_LD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (tmr_zero) begin
          state_d  = S_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PW_LD;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_PULSE: begin
        if (tmr_zero) begin
          if (rw_q) begin
            rdata_d = lcd_d_in;
          end else begin
            rdata_d = rdata_q;
          end
          if (T_AH != 0) begin
            state_d  = S_HOLD;
            tmr_load = 1'b1;
            tmr_val  = AH_LD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_PULSE;
        end
      end
      S_HOLD: begin
        if (tmr_zero) begin
          state_d = S_DONE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DONE: begin
        if (!access) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request and registered LCD strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rs_q       <= 1'b0;
      rw_q       <= 1'b1;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      lcd_e_q    <= 1'b0;
      lcd_d_oe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      lcd_e_q    <= (state_d == S_PULSE);
      lcd_d_oe_q <= !rw_d && (state_d inside {S_SETUP, S_PULSE, S_HOLD});
    end
  end

  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = rw_q;
  assign lcd_d_out = wdata_q;
  assign lcd_d_oe  = lcd_d_oe_q;
  assign d_out     = rdata_q;
  assign d_out_oe  = (state_q == S_DONE) && rw_q && !n_oe;
  assign n_rdy     = !rst && access && (state_q != S_DONE);

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Scoreboard bench for lcd_bus_ctrl at default timing (T_AS=1, T_PW=4, T_AH=1).
module tb_lcd_bus_ctrl;
  import ccpu_io_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        n_oe, n_we;
  logic [7:0]  d_in, d_out, lcd_d_out, lcd_d_in;
  logic        d_out_oe, n_rdy, lcd_e, lcd_rs, lcd_rw, lcd_d_oe;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
    logic [3:0] len;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  lcd_bus_ctrl dut (
    .clk(clk), .rst(rst), .a(a), .n_oe(n_oe), .n_we(n_we), .d_in(d_in),
    .d_out(d_out), .d_out_oe(d_out_oe), .n_rdy(n_rdy), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d_out(lcd_d_out),
    .lcd_d_oe(lcd_d_oe), .lcd_d_in(lcd_d_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each completed lcd_e pulse is compared against the next expectation.
  int         e_cnt = 0;
  logic       c_rs, c_rw, c_doe;
  logic [7:0] c_dat;
  exp_t       e;
  always @(negedge clk) begin
    if (lcd_e === 1'b1) begin
      if (e_cnt == 0) begin
        c_rs  = lcd_rs;
        c_rw  = lcd_rw;
        c_doe = lcd_d_oe;
        c_dat = lcd_d_out;
      end
      e_cnt++;
    end else if (e_cnt != 0) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("mon_rs", 32'(c_rs), 32'(e.rs));
        check("mon_rw", 32'(c_rw), 32'(e.rw));
        check("mon_d_oe", 32'(c_doe), 32'(!e.rw));
        if (!e.rw) check("mon_wdata", 32'(c_dat), 32'(e.data));
        check("mon_e_len", 32'(e_cnt), 32'(e.len));
      end
      e_cnt = 0;
    end
  end

  // One complete CPU access held until n_rdy releases, then strobes withdrawn.
  task automatic lcd_access(input logic [15:0] addr, input logic we_n, input logic oe_n,
                            input logic [7:0] din, input logic [7:0] ldin,
                            input logic exp_rs, input logic exp_rw);
    int   n;
    int   first_e;
    logic doe_seen;
    sb.push_back('{rs: exp_rs, rw: exp_rw, data: din, len: 4'd4});
    @(negedge clk);
    a = addr; n_we = we_n; n_oe = oe_n; d_in = din; lcd_d_in = ldin;
    #1;
    n = 0; first_e = 0; doe_seen = 1'b0;
    while (n_rdy === 1'b1 && n < 40) begin
      n++;
      if (lcd_e === 1'b1 && first_e == 0) first_e = n;
      if (lcd_d_oe === 1'b1) doe_seen = 1'b1;
      @(negedge clk);
      #1;
    end
    check("nrdy_cycles", 32'(n), 32'd7);
    check("e_rise_cycle", 32'(first_e), 32'd3);
    check("done_e_low", 32'(lcd_e), 32'd0);
    check("done_d_out_oe", 32'(d_out_oe), 32'(exp_rw));
    if (exp_rw) begin
      check("rd_d_out", 32'(d_out), 32'(ldin));
      check("rd_no_lcd_d_oe", 32'(doe_seen), 32'd0);
    end
    n_oe = 1'b1; n_we = 1'b1;
    #1;
    check("release_d_out_oe", 32'(d_out_oe), 32'd0);
    @(negedge clk);
    #1;
    check("back_idle", 32'(dut.state_q), 32'(S_IDLE));
  endtask

  // Non-LCD address: nothing may start.
  task automatic idle_probe(input logic [15:0] addr);
    @(negedge clk);
    a = addr; n_we = 1'b0; d_in = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("probe_n_rdy", 32'(n_rdy), 32'd0);
      check("probe_e", 32'(lcd_e), 32'd0);
      check("probe_state", 32'(dut.state_q), 32'(S_IDLE));
      @(negedge clk);
    end
    n_we = 1'b1;
  endtask

  initial begin
    rst = 1'b1; a = 16'h0000; n_oe = 1'b1; n_we = 1'b1; d_in = 8'h00; lcd_d_in = 8'h00;
    repeat (2) @(negedge clk);
    n_we = 1'b0; a = 16'hFF02;
    #1;
    check("rst_n_rdy", 32'(n_rdy), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd1);
    check("rst_d_oe", 32'(lcd_d_oe), 32'd0);
    check("rst_d_out", 32'(d_out), 32'h00);
    check("rst_d_out_oe", 32'(d_out_oe), 32'd0);
    n_we = 1'b1; a = 16'h0000;
    @(negedge clk);
    rst = 1'b0;

    lcd_access(16'hFF02, 1'b0, 1'b1, 8'h38, 8'h00, 1'b0, 1'b0);
    lcd_access(16'hFF02, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1);
    lcd_access(16'hFF03, 1'b1, 1'b0, 8'h11, 8'h3C, 1'b1, 1'b1);
    lcd_access(16'hFF03, 1'b0, 1'b0, 8'h41, 8'h00, 1'b1, 1'b0);
    idle_probe(16'hFF04);
    idle_probe(16'h7F02);

    // Reset during the second enable-high cycle truncates the pulse to 2.
    sb.push_back('{rs: 1'b1, rw: 1'b0, data: 8'h55, len: 4'd2});
    @(negedge clk);
    a = 16'hFF03; n_we = 1'b0; d_in = 8'h55;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_n_rdy", 32'(n_rdy), 32'd0);
    @(negedge clk);
    #1;
    check("midrst_e", 32'(lcd_e), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(S_IDLE));
    check("midrst_rw", 32'(lcd_rw), 32'd1);
    check("midrst_d_oe", 32'(lcd_d_oe), 32'd0);
    rst = 1'b0; n_we = 1'b1;
    lcd_access(16'hFF03, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b1, 1'b0);

    // CPU abort: inputs change after IDLE and the strobe drops after 2 cycles.
    sb.push_back('{rs: 1'b1, rw: 1'b0, data: 8'h5A, len: 4'd4});
    @(negedge clk);
    a = 16'hFF03; n_we = 1'b0; d_in = 8'h5A;
    #1;
    check("abort_n_rdy_hi", 32'(n_rdy), 32'd1);
    @(negedge clk);
    a = 16'hFF02; d_in = 8'hC3;
    @(negedge clk);
    n_we = 1'b1;
    #1;
    check("abort_n_rdy_lo", 32'(n_rdy), 32'd0);
    check("abort_e_high", 32'(lcd_e), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("abort_done", 32'(dut.state_q), 32'(S_DONE));
    @(negedge clk);
    #1;
    check("abort_idle", 32'(dut.state_q), 32'(S_IDLE));
    lcd_access(16'hFF02, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
